// File: rtl/dff_pipeline.sv
// dff_pipeline: enabled DEPTH-stage register pipeline with per-stage valid flags,
// synchronous flush and a running count of occupied stages.
module dff_pipeline #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_valid,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] vld;
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
            vld   <= '0;
            count <= '0;
        end else if (en) begin
            data[0] <= d;
            vld[0]  <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data[i] <= data[i-1];
                vld[i]  <= vld[i-1];
            end
            // Modular arithmetic keeps the full-and-shifting case exact at DEPTH.
            count <= count + CW'(d_valid) - CW'(vld[DEPTH-1]);
        end
    end
    assign q       = data[DEPTH-1];
    assign q_valid = vld[DEPTH-1];
endmodule

// File: tb/tb_dff_pipeline.sv
// tb_dff_pipeline: directed vector table plus randomized run against a history-based model,
// exercising a DEPTH=3 and a DEPTH=1 instance in parallel.
module tb_dff_pipeline;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, flush, d_valid;
    logic [3:0] d;
    logic [3:0] q3, q1;
    logic       qv3, qv1;
    logic [1:0] c3;
    logic       c1;

    dff_pipeline #(.WIDTH(4), .DEPTH(3), .RESET_VAL(4'h0)) dut3 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q3), .q_valid(qv3), .count(c3)
    );
    dff_pipeline #(.WIDTH(4), .DEPTH(1), .RESET_VAL(4'h0)) dut1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q1), .q_valid(qv1), .count(c1)
    );

    typedef struct {
        logic [3:0] d;
        bit         v;
    } slot_t;

    typedef struct {
        bit         r, f, e;
        logic [3:0] d;
        bit         dv;
        logic [3:0] eq;
        bit         ev;
        int         ec;
        bit         cq;
    } vec_t;

    // Words accepted on enabled edges since the last reset/flush, newest last.
    slot_t hist[$];
    vec_t  tbl[$];
    int    total = 0;
    int    bad = 0;
    bit    rand_phase = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag, input int dep, input logic [3:0] aq,
                               input logic av, input logic [1:0] ac);
        int n, ec;
        bit ev;
        logic [3:0] eq;
        n = hist.size();
        ev = 0;
        eq = 4'h0;
        ec = 0;
        for (int k = 0; k < dep && k < n; k++) ec += int'(hist[n-1-k].v);
        if (n >= dep) begin
            ev = hist[n-dep].v;
            eq = hist[n-dep].d;
        end
        chk({tag, "_qv"}, 32'(av), 32'(ev));
        chk({tag, "_cnt"}, 32'(ac), 32'(ec));
        if (ev || n < dep) chk({tag, "_q"}, 32'(aq), 32'(eq));
    endtask

    task automatic tick(input bit r, input bit f, input bit e, input logic [3:0] dd, input bit dv);
        reset = r; flush = f; en = e; d = dd; d_valid = dv;
        @(posedge clk);
        #1;
        if (r || f) hist.delete();
        else if (e) begin
            hist.push_back('{d: dd, v: dv});
            if (hist.size() > 3) void'(hist.pop_front());
        end
        check_model("d1", 1, q1, qv1, {1'b0, c1});
        if (rand_phase) check_model("d3", 3, q3, qv3, c3);
    endtask

    task automatic add(input bit r, input bit f, input bit e, input logic [3:0] dd, input bit dv,
                       input logic [3:0] eq, input bit ev, input int ec, input bit cq);
        tbl.push_back('{r: r, f: f, e: e, d: dd, dv: dv, eq: eq, ev: ev, ec: ec, cq: cq});
    endtask

    initial begin
        // reset held two edges with live inputs
        add(1,0,1,4'hF,1, 4'h0,0,0,1);
        add(1,0,1,4'hF,1, 4'h0,0,0,1);
        // fill and latency
        add(0,0,1,4'h1,1, 4'h0,0,1,1);
        add(0,0,1,4'h2,1, 4'h0,0,2,1);
        add(0,0,1,4'h3,1, 4'h1,1,3,1);
        add(0,0,1,4'h4,1, 4'h2,1,3,1);
        add(0,0,1,4'h0,0, 4'h3,1,2,1);
        add(0,0,1,4'h0,0, 4'h4,1,1,1);
        add(0,0,1,4'h0,0, 4'h0,0,0,0);
        // stall
        add(1,0,0,4'h0,0, 4'h0,0,0,1);
        add(0,0,1,4'hA,1, 4'h0,0,1,1);
        add(0,0,1,4'hB,1, 4'h0,0,2,1);
        add(0,0,1,4'hC,1, 4'hA,1,3,1);
        for (int i = 0; i < 5; i++) add(0,0,0,4'h5,1, 4'hA,1,3,1);
        add(0,0,1,4'h0,0, 4'hB,1,2,1);
        add(0,0,1,4'h0,0, 4'hC,1,1,1);
        add(0,0,1,4'h0,0, 4'h0,0,0,0);
        // bubbles
        add(0,0,1,4'h7,1, 4'h0,0,1,0);
        add(0,0,1,4'h8,0, 4'h0,0,1,0);
        add(0,0,1,4'h9,1, 4'h7,1,2,1);
        add(0,0,1,4'h0,0, 4'h0,0,1,0);
        add(0,0,1,4'h0,0, 4'h9,1,1,1);
        add(0,0,1,4'h0,0, 4'h0,0,0,0);
        // flush beats en; then reset together with flush
        for (int p = 0; p < 2; p++) begin
            add(0,0,1,4'h1,1, 4'h0,0,1,0);
            add(0,0,1,4'h2,1, 4'h0,0,2,0);
            add(0,0,1,4'h3,1, 4'h1,1,3,1);
            add(p == 1,1,1,4'hE,1, 4'h0,0,0,1);
            for (int i = 0; i < 3; i++) add(0,0,1,4'h0,0, 4'h0,0,0,1);
        end

        foreach (tbl[i]) begin
            tick(tbl[i].r, tbl[i].f, tbl[i].e, tbl[i].d, tbl[i].dv);
            chk($sformatf("v%0d_qv", i), 32'(qv3), 32'(tbl[i].ev));
            chk($sformatf("v%0d_cnt", i), 32'(c3), 32'(tbl[i].ec));
            if (tbl[i].cq) chk($sformatf("v%0d_q", i), 32'(q3), 32'(tbl[i].eq));
        end

        rand_phase = 1;
        for (int i = 0; i < 400; i++)
            tick($urandom_range(39) == 0, $urandom_range(19) == 0, $urandom_range(3) != 0,
                 4'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dff_pipeline.md
DFF_PIPELINE -- requirements
Module: dff_pipeline

Interface
REQ-001 The module SHALL expose the parameter WIDTH, default 4: data width in bits, legal range 1 or more.
REQ-002 The module SHALL expose the parameter DEPTH, default 2: number of register stages, legal range 1 or more.
REQ-003 The module SHALL expose the parameter RESET_VAL, default all zeros: value loaded into every data stage on reset and on flush; it is WIDTH bits wide.
REQ-004 The module SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL provide port en, input, 1 bit: advance enable; 1 shifts the pipeline, 0 holds all state.
REQ-007 The module SHALL provide port flush, input, 1 bit: synchronous clear of pipeline contents without full reset.
REQ-008 The module SHALL provide port d, input, WIDTH bits: data into stage 0.
REQ-009 The module SHALL provide port d_valid, input, 1 bit: qualifies d.
REQ-010 The module SHALL provide port q, output, WIDTH bits: data of the last stage (stage DEPTH-1).
REQ-011 The module SHALL provide port q_valid, output, 1 bit: valid flag of the last stage.
REQ-012 The module SHALL provide port count, output, $clog2(DEPTH+1) bits: number of stages currently holding valid data.

Function
REQ-013 Each stage i SHALL hold a WIDTH-bit data register and a 1-bit valid flag; all outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-014 The priority of control inputs at a rising edge SHALL be: reset first, then flush, then en.
REQ-015 With en=1 and no reset or flush, the pipeline SHALL shift one stage:
  - stage 0 loads d and d_valid;
  - stage i loads stage i-1, for i = 1 to DEPTH-1.
REQ-016 With en=0 and no reset or flush, every data register, valid flag and count SHALL hold.
REQ-017 Latency SHALL be exactly DEPTH enabled edges from d sampled to q/q_valid; edges with en=0 do not count.
REQ-018 Data SHALL shift regardless of d_valid; invalid slots (bubbles) propagate with valid=0, and the data in those slots is don't-care to consumers.
REQ-019 flush=1 SHALL set every data stage to RESET_VAL, every valid flag to 0 and count to 0 on that edge, and SHALL discard d on that edge even if en=1.
REQ-020 When en=1, count SHALL update to count + d_valid - (valid of stage DEPTH-1), evaluated on pre-edge values.
REQ-021 count SHALL always equal the popcount of the valid flags and SHALL never leave the range 0 to DEPTH, including when full and shifting a valid word in while one shifts out.
REQ-022 With DEPTH=1, the block SHALL behave as a single enabled register with valid flag, and count SHALL be 1 bit wide.
REQ-023 When d_valid=1 and en=0, the input SHALL be dropped; no internal skid storage is permitted.

Reset
REQ-024 While reset=1 at a rising edge, every data stage SHALL load RESET_VAL, every valid flag SHALL load 0, and count SHALL load 0, regardless of en, flush, d and d_valid.
REQ-025 After that edge, q SHALL equal RESET_VAL, q_valid SHALL be 0 and count SHALL be 0.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight data; the first enabled edge after reset deasserts SHALL start a fresh fill.
REQ-027 Before the first reset edge, output values SHALL be unspecified, and benches SHALL apply reset for at least 1 cycle.

Verification (WIDTH=4, DEPTH=3, RESET_VAL=4'h0, clk period 10)
REQ-028 The bench SHALL cover reset: hold reset=1 for 2 edges with d=4'hF, d_valid=1, en=1 -> q=4'h0, q_valid=0, count=0.
REQ-029 The bench SHALL cover fill and latency:
  - Stimulus: en=1; drive d=4'h1,4'h2,4'h3,4'h4 with d_valid=1 on consecutive edges.
  - Response: q=4'h1 with q_valid=1 after the 3rd edge; count reads 1, 2, 3, 3.
  - Response: q=4'h4 after the 6th edge.
REQ-030 The bench SHALL cover stall:
  - Stimulus: fill with 4'hA,4'hB,4'hC, then en=0 for 5 edges with d=4'h5, d_valid=1.
  - Response: q=4'hA and count=3 throughout the stall.
  - Response: after en=1 resumes, q steps to 4'hB then 4'hC; 4'h5 never appears unless it is presented again with en=1.
REQ-031 The bench SHALL cover bubbles: drive d_valid pattern 1,0,1 with d=4'h7,4'h8,4'h9 and en=1 -> q_valid shows 1,0,1 on edges 3,4,5; q=4'h7 and 4'h9 on the valid edges; count never exceeds 2 during those edges.
REQ-032 The bench SHALL cover flush with priority:
  - Stimulus: pipeline full (count=3); assert flush=1 with en=1, d=4'hE, d_valid=1 for one edge.
  - Response: q=4'h0, q_valid=0, count=0; 4'hE never emerges.
  - Stimulus: repeat the same edge with reset=1 as well.
  - Response: identical result, with reset taking precedence.
